cmp_resolve_unit: RTL and testbench

Parametrised, registered successor to the branch comparator in the decode stage. It accepts operand pairs with an opcode and evaluates eight compare modes, signed and unsigned, at any data width. Results pass through a 2-entry elastic buffer with valid/ready handshakes on both sides, so the branch unit can backpressure. A flush input discards in-flight results on pipeline redirect.

---
 rtl/cmp_resolve_unit.sv | 145 ++++++++++++++
 tb/tb_cmp_resolve_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_resolve_unit.sv
// cmp_resolve_unit: registered branch comparator with a 2-entry elastic
// output buffer, valid/ready handshakes on both sides and a pipeline flush.
// Optional delivery statistics are enabled with `define CMP_RESOLVE_STATS_EN.
module cmp_resolve_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [2:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] stat_total,
    output logic [CNT_W-1:0] stat_taken
);

    localparam int ENTRY_W = 1 + 3 + TAG_W;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LEZ = 3'd2,
        OP_GTZ = 3'd3,
        OP_LTZ = 3'd4,
        OP_GEZ = 3'd5,
        OP_LT  = 3'd6,
        OP_LTU = 3'd7
    } cmpOpT;

    logic               aZero;
    logic               aNeg;
    logic               abEqual;
    logic               abLessSigned;
    logic               abLessUnsigned;
    logic               newTaken;
    logic [2:0]         newFlags;
    logic [ENTRY_W-1:0] newEntry;

    logic [ENTRY_W-1:0] entryMem [2];
    logic [1:0]         count;
    logic               headPtr;
    logic               tailPtr;
    logic               pushEn;
    logic               popEn;
    logic [ENTRY_W-1:0] headEntry;

    assign aZero          = (in_a == '0);
    assign aNeg           = in_a[WIDTH-1];
    assign abEqual        = (in_a == in_b);
    assign abLessSigned   = ($signed(in_a) < $signed(in_b));
    assign abLessUnsigned = (in_a < in_b);
    assign newFlags       = {aZero, ~aNeg, abEqual};
    assign newEntry       = {newTaken, newFlags, in_tag};

    // Select the compare outcome for the requested mode
    always_comb begin
        newTaken = 1'b0;
        case (cmpOpT'(in_op))
            OP_EQ:   newTaken = abEqual;
            OP_NE:   newTaken = ~abEqual;
            OP_LEZ:  newTaken = aNeg | aZero;
            OP_GTZ:  newTaken = ~aNeg & ~aZero;
            OP_LTZ:  newTaken = aNeg;
            OP_GEZ:  newTaken = ~aNeg;
            OP_LT:   newTaken = abLessSigned;
            OP_LTU:  newTaken = abLessUnsigned;
            default: newTaken = 1'b0;
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign pushEn    = in_valid && in_ready;
    assign popEn     = out_valid && out_ready;
    assign headEntry = entryMem[headPtr];

    // Buffer state: flush beats push and pop; push and pop may overlap
    always_ff @(posedge clk) begin
        if (!reset) begin
            count       <= 2'd0;
            headPtr     <= 1'b0;
            tailPtr     <= 1'b0;
            entryMem[0] <= '0;
            entryMem[1] <= '0;
        end else if (flush) begin
            count   <= 2'd0;
            headPtr <= 1'b0;
            tailPtr <= 1'b0;
        end else begin
            if (pushEn) begin
                entryMem[tailPtr] <= newEntry;
                tailPtr           <= ~tailPtr;
            end
            if (popEn) begin
                headPtr <= ~headPtr;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_taken = out_valid & headEntry[ENTRY_W-1];
    assign out_flags = out_valid ? headEntry[ENTRY_W-2 -: 3] : 3'b000;
    assign out_tag   = out_valid ? headEntry[TAG_W-1:0] : '0;

`ifdef CMP_RESOLVE_STATS_EN
    logic [CNT_W-1:0] totalCount;
    logic [CNT_W-1:0] takenCount;

    // Saturating delivery counters; only reset clears them, never flush
    always_ff @(posedge clk) begin
        if (!reset) begin
            totalCount <= '0;
            takenCount <= '0;
        end else if (popEn) begin
            if (totalCount != {CNT_W{1'b1}}) begin
                totalCount <= totalCount + 1'b1;
            end
            if (out_taken && (takenCount != {CNT_W{1'b1}})) begin
                takenCount <= takenCount + 1'b1;
            end
        end
    end

    assign stat_total = totalCount;
    assign stat_taken = takenCount;
`else
    assign stat_total = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_cmp_resolve_unit.sv
// Testbench for cmp_resolve_unit: scoreboard of expected results, compared
// against the presented head entry every cycle on the falling clock edge.
module tb_cmp_resolve_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
`ifdef CMP_RESOLVE_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk;
    logic             reset;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic [2:0]       inOp;
    logic [TAG_W-1:0] inTag;
    logic             flush;
    logic             outValid;
    logic             outReady;
    logic             outTaken;
    logic [2:0]       outFlags;
    logic [TAG_W-1:0] outTag;
    logic [CNT_W-1:0] statTotal;
    logic [CNT_W-1:0] statTaken;

    logic [8:0]       sbQ [$];
    int               errorCount = 0;
    int               checkCount = 0;
    bit               checkEn    = 1'b0;
    logic [CNT_W-1:0] modelTotal = '0;
    logic [CNT_W-1:0] modelTaken = '0;

    cmp_resolve_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_op      (inOp),
        .in_tag     (inTag),
        .flush      (flush),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_taken  (outTaken),
        .out_flags  (outFlags),
        .out_tag    (outTag),
        .stat_total (statTotal),
        .stat_taken (statTaken)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference result {taken, zero, gez, eq, tag}
    function automatic logic [8:0] refResult(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic [4:0] tag);
        logic eq, zero, neg, ltS, ltU, taken;
        eq   = (a == b);
        zero = (a == 32'd0);
        neg  = a[31];
        ltU  = (a < b);
        ltS  = (a[31] != b[31]) ? a[31] : ltU;
        case (op)
            3'd0: taken = eq;
            3'd1: taken = !eq;
            3'd2: taken = neg || zero;
            3'd3: taken = !neg && !zero;
            3'd4: taken = neg;
            3'd5: taken = !neg;
            3'd6: taken = ltS;
            default: taken = ltU;
        endcase
        return {taken, zero, !neg, eq, tag};
    endfunction

    // Compare DUT against the scoreboard, then advance the model to the next edge
    always @(negedge clk) begin
        if (checkEn) begin
            logic [8:0] expEntry;
            logic [CNT_W-1:0] expTotal;
            logic [CNT_W-1:0] expTaken;
            bit pushNow;
            bit popNow;
            expEntry = (sbQ.size() > 0) ? sbQ[0] : 9'd0;
`ifdef CMP_RESOLVE_STATS_EN
            expTotal = modelTotal;
            expTaken = modelTaken;
`else
            expTotal = '0;
            expTaken = '0;
`endif
            checkOutput("in_ready", 32'(inReady), 32'(sbQ.size() < 2));
            checkOutput("out_valid", 32'(outValid), 32'(sbQ.size() > 0));
            checkOutput("out_taken", 32'(outTaken), 32'(expEntry[8]));
            checkOutput("out_flags", 32'(outFlags), 32'(expEntry[7:5]));
            checkOutput("out_tag", 32'(outTag), 32'(expEntry[4:0]));
            checkOutput("stat_total", 32'(statTotal), 32'(expTotal));
            checkOutput("stat_taken", 32'(statTaken), 32'(expTaken));

            if (!reset) begin
                sbQ.delete();
                modelTotal = '0;
                modelTaken = '0;
            end else begin
                popNow  = (sbQ.size() > 0) && outReady;
                pushNow = inValid && (sbQ.size() < 2);
                if (popNow) begin
                    if (modelTotal != {CNT_W{1'b1}}) modelTotal = modelTotal + 1'b1;
                    if (expEntry[8] && modelTaken != {CNT_W{1'b1}}) modelTaken = modelTaken + 1'b1;
                end
                if (flush) begin
                    sbQ.delete();
                end else begin
                    if (popNow) void'(sbQ.pop_front());
                    if (pushNow) sbQ.push_back(refResult(inA, inB, inOp, inTag));
                end
            end
        end
    end

    // Present one operand pair for a single cycle
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [4:0] tag);
        inValid = 1'b1;
        inA     = a;
        inB     = b;
        inOp    = op;
        inTag   = tag;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset    = 1'b0;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        inOp     = '0;
        inTag    = '0;
        flush    = 1'b0;
        outReady = 1'b0;
        checkEn  = 1'b1;

        // Reset held for two cycles
        idleCycles(2);
        reset = 1'b1;
        idleCycles(1);

        // Signed versus unsigned less-than on all-ones operand
        outReady = 1'b1;
        applyStimulus(32'hFFFF_FFFF, 32'h1, 3'd6, 5'd4);
        applyStimulus(32'hFFFF_FFFF, 32'h1, 3'd7, 5'd5);
        idleCycles(2);

        // Zero-operand modes and equality
        applyStimulus(32'h0, 32'h0, 3'd2, 5'd6);
        applyStimulus(32'h0, 32'h0, 3'd3, 5'd7);
        applyStimulus(32'h1234, 32'h1234, 3'd0, 5'd8);
        idleCycles(2);

        // Backpressure: third push must be refused, then drain in order
        outReady = 1'b0;
        applyStimulus(32'h5, 32'h5, 3'd1, 5'd1);
        applyStimulus(32'h5, 32'h6, 3'd1, 5'd2);
        applyStimulus(32'h5, 32'h7, 3'd1, 5'd3);
        idleCycles(1);
        outReady = 1'b1;
        idleCycles(3);

        // Flush with a full buffer and a simultaneous push
        outReady = 1'b0;
        applyStimulus(32'h1, 32'h2, 3'd6, 5'd9);
        applyStimulus(32'h2, 32'h1, 3'd6, 5'd10);
        flush = 1'b1;
        applyStimulus(32'h3, 32'h3, 3'd0, 5'd11);
        flush = 1'b0;
        idleCycles(2);

        // Reset in the middle of traffic drops everything
        applyStimulus(32'h9, 32'h9, 3'd0, 5'd12);
        reset = 1'b0;
        idleCycles(1);
        reset = 1'b1;
        outReady = 1'b1;
        idleCycles(2);

        // Five taken deliveries, then a flush that must not touch the counters
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'(i), 32'(i), 3'd0, 5'(i));
        end
        idleCycles(2);
        flush = 1'b1;
        idleCycles(1);
        flush = 1'b0;
        idleCycles(1);

        // Random traffic with boundary operands, backpressure and flushes
        for (int i = 0; i < 400; i++) begin
            inValid  = 1'($urandom_range(0, 1));
            inA      = pickOperand();
            inB      = ($urandom_range(0, 3) == 0) ? inA : pickOperand();
            inOp     = 3'($urandom_range(0, 7));
            inTag    = 5'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        inValid  = 1'b0;
        flush    = 1'b0;
        outReady = 1'b1;
        idleCycles(4);

        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
